line_sensor_proc: RTL

Consumes the 12-bit channel results produced by the SPI ADC interface stage and turns the three line-sensor channels into a filtered black/white pattern, a signed steering error and a node (junction) strobe for the motor-control stage. Each channel goes through a 4-sample moving average and a hysteresis threshold, then a decode stage. The block is fully pipelined: it accepts one ADC frame per `adc_valid` pulse, back-to-back if needed, and produces one result two cycles later.

---
 rtl/line_sensor_proc.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/line_sensor_proc.sv
// Line-sensor pre-processing: per-channel 4-sample moving average and hysteresis threshold,
// then decode of the {L,C,R} black/white pattern into a steering error, a lost flag and a node strobe.
module line_sensor_proc #(
  parameter logic [11:0] TH_HI       = 12'd2000,
  parameter logic [11:0] TH_LO       = 12'd1800,
  parameter int          NODE_FRAMES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adc_valid,
  input  logic [11:0]       adc1,
  input  logic [11:0]       adc2,
  input  logic [11:0]       adc3,
  output logic              out_valid,
  output logic [2:0]        pattern,
  output logic signed [2:0] line_err,
  output logic              lost,
  output logic              node
);

  localparam int NCW = $clog2(NODE_FRAMES + 1);
  localparam logic [NCW-1:0] NODE_MAX = NCW'(NODE_FRAMES);

  typedef enum logic {FILL, RUN} state_t;

  // Channel index 2 = left, 1 = centre, 0 = right, so a packed bit vector reads as {L,C,R}.
  logic [11:0]       sample   [3];
  logic [11:0]       hist_q   [3][4];
  logic [13:0]       sum_q    [3];
  logic [13:0]       sum_d    [3];
  logic [11:0]       avg      [3];

  state_t            state_q;
  logic [1:0]        fill_cnt_q;
  logic              s1_valid_q;
  logic              s1_emit_q;

  logic [2:0]        black_q;
  logic [2:0]        black_d;
  logic signed [2:0] line_err_q;
  logic signed [2:0] line_err_d;
  logic [NCW-1:0]    node_cnt_q;
  logic [NCW-1:0]    node_cnt_d;
  logic              node_d;
  logic              out_valid_q;
  logic [2:0]        pattern_q;
  logic              lost_q;
  logic              node_q;

  assign sample[2] = adc1;
  assign sample[1] = adc2;
  assign sample[0] = adc3;

  // The true sum always fits in 14 bits, so modular wrap of the intermediate add/subtract is harmless.
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      sum_d[c]   = sum_q[c] + 14'(sample[c]) - 14'(hist_q[c][3]);
      avg[c]     = sum_q[c][13:2];
      // NOTE: every always_comb output gets a value on every path, else synthesis infers a latch.
      black_d[c] = black_q[c];
      if (avg[c] > TH_HI)      black_d[c] = 1'b1;
      else if (avg[c] < TH_LO) black_d[c] = 1'b0;
    end
  end

  always_comb begin
    line_err_d = line_err_q;
    case (black_d)
      3'b010:  line_err_d = 3'sd0;
      3'b110:  line_err_d = -3'sd1;
      3'b100:  line_err_d = -3'sd2;
      3'b011:  line_err_d = 3'sd1;
      3'b001:  line_err_d = 3'sd2;
      3'b111:  line_err_d = 3'sd0;
      default: line_err_d = line_err_q;
    endcase
  end

  always_comb begin
    node_cnt_d = '0;
    node_d     = 1'b0;
    if (black_d == 3'b111) begin
      node_cnt_d = (node_cnt_q == NODE_MAX) ? node_cnt_q : node_cnt_q + 1'b1;
      node_d     = (node_cnt_q == NODE_MAX - 1'b1);
    end
  end

  // Stage 1: sample history, running sums and FILL/RUN sequencing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the history is a handful of registers whose reset to 0 makes the FILL averages defined;
      // a large RAM-style memory would normally be left unreset.
      for (int c = 0; c < 3; c++) begin
        sum_q[c] <= '0;
        for (int k = 0; k < 4; k++) hist_q[c][k] <= '0;
      end
      state_q    <= FILL;
      fill_cnt_q <= '0;
      s1_valid_q <= 1'b0;
      s1_emit_q  <= 1'b0;
    end else begin
      // NOTE: clocked state uses <= so every register samples pre-edge values regardless of statement order.
      s1_valid_q <= adc_valid;
      s1_emit_q  <= adc_valid && (state_q == RUN || fill_cnt_q == 2'd3);
      if (adc_valid) begin
        for (int c = 0; c < 3; c++) begin
          sum_q[c]     <= sum_d[c];
          hist_q[c][0] <= sample[c];
          for (int k = 1; k < 4; k++) hist_q[c][k] <= hist_q[c][k-1];
        end
        if (state_q == FILL) begin
          fill_cnt_q <= fill_cnt_q + 2'd1;
          if (fill_cnt_q == 2'd3) state_q <= RUN;
        end
      end
    end
  end

  // Stage 2: hysteresis bits track every frame; visible outputs only move on emitted frames.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      black_q     <= '0;
      line_err_q  <= '0;
      node_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      pattern_q   <= '0;
      lost_q      <= 1'b0;
      node_q      <= 1'b0;
    end else begin
      out_valid_q <= s1_emit_q;
      node_q      <= 1'b0;
      if (s1_valid_q) black_q <= black_d;
      if (s1_emit_q) begin
        pattern_q  <= black_d;
        line_err_q <= line_err_d;
        lost_q     <= (black_d == 3'b000);
        node_cnt_q <= node_cnt_d;
        node_q     <= node_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign pattern   = pattern_q;
  assign line_err  = line_err_q;
  assign lost      = lost_q;
  assign node      = node_q;

endmodule
